// File: rtl/qspi_memory_slave.sv
// rtl/qspi_memory_slave.sv - 1/2/4-lane SPI memory target with oversampled pins and internal byte RAM
module qspi_memory_slave #(
    parameter int LANES        = 2,
    parameter int DEPTH        = 256,
    parameter int ADDR_BYTES   = 2,
    parameter int DUMMY_CYCLES = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SS,
    input  logic             SCLK,
    input  logic [LANES-1:0] QD_READ,
    output logic [LANES-1:0] QD_WRITE,
    output logic [LANES-1:0] QD_WRITE_ENABLE,
    output logic             XFER_DONE,
    output logic [15:0]      BYTE_COUNT,
    output logic             CMD_ERR
);
    localparam int AW     = $clog2(DEPTH);
    localparam int SHIFTS = 8 / LANES;
    localparam int BW     = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
    localparam logic [BW-1:0] BIT_LAST   = BW'(SHIFTS - 1);
    localparam logic [1:0]    ADDR_LAST  = 2'(ADDR_BYTES - 1);
    localparam logic [3:0]    DUMMY_LAST = 4'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);
    localparam logic [7:0]    CMD_WRITE  = 8'h02;
    localparam logic [7:0]    CMD_READ   = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_RD_DATA,
        S_WR_DATA,
        S_REJECT
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       ss_sync, sclk_sync;
    logic             ss_prev, sclk_prev;
    logic [LANES-1:0] qd_d1, qd_d2;
    logic             ss_rise, ss_fall, sclk_rise, sclk_fall;

    logic [7-LANES:0] rx_shift;
    logic [7:0]       rx_byte;
    logic             rx_done;
    logic [BW-1:0]    bit_cnt, fall_cnt;
    logic [1:0]       addr_cnt;
    logic [3:0]       dummy_cnt;
    logic [AW-1:0]    addr, addr_load, addr_inc;
    logic             is_write;
    logic [7:0]       rd_buf, tx_shift;
    logic             oe;
    logic             mem_we;
    logic [7:0]       mem [DEPTH];

    // Synchronisers are left unreset so a pin already low during reset never looks like a fresh SS fall.
    always_ff @(posedge CLK) begin
        ss_sync   <= {ss_sync[0], SS};
        sclk_sync <= {sclk_sync[0], SCLK};
        ss_prev   <= ss_sync[1];
        sclk_prev <= sclk_sync[1];
        qd_d1     <= QD_READ;
        qd_d2     <= qd_d1;
    end

    assign ss_rise   = ss_sync[1] & ~ss_prev;
    assign ss_fall   = ~ss_sync[1] & ss_prev;
    assign sclk_rise = sclk_sync[1] & ~sclk_prev & ~ss_rise;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev & ~ss_rise;

    assign rx_byte   = {rx_shift, qd_d2};
    assign rx_done   = sclk_rise && (bit_cnt == BIT_LAST);
    assign addr_load = AW'({addr, rx_byte});
    assign addr_inc  = addr + AW'(1);
    assign mem_we    = RST && (state == S_WR_DATA) && rx_done;

    assign QD_WRITE_ENABLE = {LANES{oe}};

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ss_rise) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ss_fall) state_nxt = S_CMD;
                end
                S_CMD: begin
                    if (rx_done) begin
                        state_nxt = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? S_ADDR : S_REJECT;
                    end
                end
                S_ADDR: begin
                    if (rx_done && addr_cnt == ADDR_LAST) begin
                        if (is_write) state_nxt = S_WR_DATA;
                        else if (DUMMY_CYCLES > 0) state_nxt = S_DUMMY;
                        else state_nxt = S_RD_DATA;
                    end
                end
                S_DUMMY: begin
                    if (sclk_rise && dummy_cnt == DUMMY_LAST) state_nxt = S_RD_DATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem[addr] <= rx_byte;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rx_shift   <= '0;
            bit_cnt    <= '0;
            fall_cnt   <= '0;
            addr_cnt   <= '0;
            dummy_cnt  <= '0;
            addr       <= '0;
            is_write   <= 1'b0;
            rd_buf     <= '0;
            tx_shift   <= '0;
            oe         <= 1'b0;
            QD_WRITE   <= '0;
            XFER_DONE  <= 1'b0;
            BYTE_COUNT <= '0;
            CMD_ERR    <= 1'b0;
        end else begin
            XFER_DONE <= 1'b0;
            if (ss_rise) begin
                oe        <= 1'b0;
                QD_WRITE  <= '0;
                bit_cnt   <= '0;
                fall_cnt  <= '0;
                XFER_DONE <= (state == S_RD_DATA) || (state == S_WR_DATA);
            end else if (state == S_IDLE) begin
                if (ss_fall) begin
                    BYTE_COUNT <= '0;
                    bit_cnt    <= '0;
                    fall_cnt   <= '0;
                    addr_cnt   <= '0;
                    dummy_cnt  <= '0;
                end
            end else begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte[7-LANES:0];
                    bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
                    if (state == S_DUMMY) dummy_cnt <= dummy_cnt + 4'd1;
                end
                if (rx_done) begin
                    case (state)
                        S_CMD: begin
                            is_write <= (rx_byte == CMD_WRITE);
                            if (rx_byte != CMD_WRITE && rx_byte != CMD_READ) CMD_ERR <= 1'b1;
                        end
                        S_ADDR: begin
                            // Prefetch on every address byte; the last one leaves the first read byte ready.
                            addr     <= addr_load;
                            addr_cnt <= addr_cnt + 2'd1;
                            rd_buf   <= mem[addr_load];
                        end
                        S_WR_DATA: begin
                            addr <= addr_inc;
                            if (BYTE_COUNT != 16'hFFFF) BYTE_COUNT <= BYTE_COUNT + 16'd1;
                        end
                        S_RD_DATA: begin
                            addr   <= addr_inc;
                            rd_buf <= mem[addr_inc];
                            if (BYTE_COUNT != 16'hFFFF) BYTE_COUNT <= BYTE_COUNT + 16'd1;
                        end
                        default: ;
                    endcase
                end
                // The fall ending the last address/dummy cycle is the first one seen in RD_DATA.
                if (sclk_fall && state == S_RD_DATA) begin
                    oe <= 1'b1;
                    if (fall_cnt == '0) begin
                        QD_WRITE <= rd_buf[7 -: LANES];
                        tx_shift <= rd_buf << LANES;
                    end else begin
                        QD_WRITE <= tx_shift[7 -: LANES];
                        tx_shift <= tx_shift << LANES;
                    end
                    fall_cnt <= (fall_cnt == BIT_LAST) ? '0 : fall_cnt + BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_qspi_memory_slave.sv
// tb/tb_qspi_memory_slave.sv - scoreboard bench for a 2-lane default slave and a 4-lane two-dummy-cycle slave
module tb_qspi_memory_slave;
    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss0, ss1, sclk;
    logic [3:0]  qd;
    logic [1:0]  qw0, oe0;
    logic        done0, err0;
    logic [15:0] bc0;
    logic [3:0]  qw1, oe1;
    logic        done1, err1;
    logic [15:0] bc1;

    int n_tests = 0;
    int n_fail  = 0;
    int done0_cnt = 0, done1_cnt = 0, oe0_cyc = 0, oe1_cyc = 0;
    int sel, lanes;

    logic [7:0] ref0 [256];
    logic [7:0] ref1 [256];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    logic [7:0] tx_q [$];

    always #5 clk = ~clk;

    qspi_memory_slave dut0 (
        .CLK(clk), .RST(rst), .SS(ss0), .SCLK(sclk), .QD_READ(qd[1:0]),
        .QD_WRITE(qw0), .QD_WRITE_ENABLE(oe0), .XFER_DONE(done0),
        .BYTE_COUNT(bc0), .CMD_ERR(err0)
    );

    qspi_memory_slave #(.LANES(4), .DUMMY_CYCLES(2)) dut1 (
        .CLK(clk), .RST(rst), .SS(ss1), .SCLK(sclk), .QD_READ(qd),
        .QD_WRITE(qw1), .QD_WRITE_ENABLE(oe1), .XFER_DONE(done1),
        .BYTE_COUNT(bc1), .CMD_ERR(err1)
    );

    always @(negedge clk) begin
        if (done0) done0_cnt <= done0_cnt + 1;
        if (done1) done1_cnt <= done1_cnt + 1;
        if (|oe0) oe0_cyc <= oe0_cyc + 1;
        if (|oe1) oe1_cyc <= oe1_cyc + 1;
    end

    task automatic sclk_cycle(input logic [3:0] dout, output logic [3:0] din);
        qd = dout;
        #(HALF);
        din = (sel == 0) ? {2'b00, qw0} : qw1;
        sclk = 1'b1;
        #(HALF);
        sclk = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic [7:0] t;
        logic [3:0] din;
        t = tx;
        rx = 8'h00;
        for (int i = 0; i < 8 / lanes; i++) begin
            sclk_cycle(4'(t >> (8 - lanes)), din);
            t = t << lanes;
            rx = (rx << lanes) | (8'(din) & 8'((1 << lanes) - 1));
        end
    endtask

    task automatic begin_xfer(input logic [7:0] cmd, input logic [15:0] addr);
        logic [7:0] rx;
        if (sel == 0) ss0 = 1'b0; else ss1 = 1'b0;
        #(HALF);
        xfer_byte(cmd, rx);
        xfer_byte(addr[15:8], rx);
        xfer_byte(addr[7:0], rx);
    endtask

    task automatic end_xfer();
        #(HALF);
        ss0 = 1'b1;
        ss1 = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic do_write(input logic [15:0] addr);
        logic [7:0] rx, b;
        int a;
        a = addr % 256;
        begin_xfer(8'h02, addr);
        while (tx_q.size() > 0) begin
            b = tx_q.pop_front();
            xfer_byte(b, rx);
            if (sel == 0) ref0[a] = b; else ref1[a] = b;
            a = (a + 1) % 256;
        end
        end_xfer();
    endtask

    task automatic do_read(input logic [15:0] addr, input int n);
        logic [7:0] rx;
        int a;
        a = addr % 256;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(ref0[a]);
            a = (a + 1) % 256;
        end
        begin_xfer(8'h03, addr);
        for (int i = 0; i < n; i++) begin
            xfer_byte(8'h00, rx);
            got_q.push_back(rx);
        end
        end_xfer();
    endtask

    task automatic test_reset();
        n_tests++; if (oe0 !== 2'b00) begin n_fail++; $display("FAIL reset_oe0 got %b expected 00", oe0); end
        n_tests++; if (qw0 !== 2'b00) begin n_fail++; $display("FAIL reset_qw0 got %b expected 00", qw0); end
        n_tests++; if (bc0 !== 16'h0) begin n_fail++; $display("FAIL reset_bc0 got %h expected 0000", bc0); end
        n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err0 got %b expected 0", err0); end
        n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done0 got %b expected 0", done0); end
        n_tests++; if (oe1 !== 4'h0) begin n_fail++; $display("FAIL reset_oe1 got %h expected 0", oe1); end
    endtask

    task automatic test_write_read();
        logic [7:0] e, g;
        int d;
        sel = 0; lanes = 2;
        d = done0_cnt;
        tx_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_write(16'h0010);
        n_tests++; if (bc0 !== 16'd4) begin n_fail++; $display("FAIL wr_byte_count got %0d expected 4", bc0); end
        do_read(16'h0010, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL wr_rd_data got %h expected %h", g, e); end
        end
        n_tests++; if (bc0 !== 16'd4) begin n_fail++; $display("FAIL rd_byte_count got %0d expected 4", bc0); end
        n_tests++; if (done0_cnt - d !== 2) begin n_fail++; $display("FAIL wr_rd_done got %0d expected 2", done0_cnt - d); end
    endtask

    task automatic test_wrap();
        logic [7:0] e, g;
        sel = 0; lanes = 2;
        tx_q = '{8'h11, 8'h22, 8'h33};
        do_write(16'h00FE);
        n_tests++; if (bc0 !== 16'd3) begin n_fail++; $display("FAIL wrap_byte_count got %0d expected 3", bc0); end
        do_read(16'h01FF, 2);
        do_read(16'h00FE, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL wrap_data got %h expected %h", g, e); end
        end
    endtask

    task automatic test_partial_byte();
        logic [7:0] rx, e, g;
        logic [3:0] din;
        int d, o;
        sel = 0; lanes = 2;
        tx_q = '{8'h5C};
        do_write(16'h0041);
        d = done0_cnt; o = oe0_cyc;
        begin_xfer(8'h02, 16'h0040);
        xfer_byte(8'h77, rx);
        ref0[8'h40] = 8'h77;
        sclk_cycle(4'h2, din);
        sclk_cycle(4'h0, din);
        end_xfer();
        n_tests++; if (bc0 !== 16'd1) begin n_fail++; $display("FAIL partial_byte_count got %0d expected 1", bc0); end
        n_tests++; if (oe0_cyc !== o) begin n_fail++; $display("FAIL partial_oe got %0d cycles expected 0", oe0_cyc - o); end
        n_tests++; if (done0_cnt - d !== 1) begin n_fail++; $display("FAIL partial_done got %0d expected 1", done0_cnt - d); end
        do_read(16'h0040, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL partial_data got %h expected %h", g, e); end
        end
    endtask

    task automatic test_reject();
        logic [7:0] rx, e, g;
        int d, o;
        sel = 0; lanes = 2;
        d = done0_cnt; o = oe0_cyc;
        begin_xfer(8'h9F, 16'h0010);
        xfer_byte(8'hEE, rx);
        xfer_byte(8'hEE, rx);
        end_xfer();
        n_tests++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL reject_err got %b expected 1", err0); end
        n_tests++; if (oe0_cyc !== o) begin n_fail++; $display("FAIL reject_oe got %0d cycles expected 0", oe0_cyc - o); end
        n_tests++; if (done0_cnt !== d) begin n_fail++; $display("FAIL reject_done got %0d expected 0", done0_cnt - d); end
        n_tests++; if (bc0 !== 16'd0) begin n_fail++; $display("FAIL reject_byte_count got %0d expected 0", bc0); end
        do_read(16'h0010, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL reject_then_read got %h expected %h", g, e); end
        end
        n_tests++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL reject_err_sticky got %b expected 1", err0); end
    endtask

    task automatic test_dummy_quad();
        logic [7:0] rx, e;
        logic [3:0] din, hi, lo;
        int d, o;
        sel = 1; lanes = 4;
        tx_q = '{8'h5A};
        do_write(16'h0020);
        exp_q.push_back(ref1[8'h20]);
        d = done1_cnt;
        begin_xfer(8'h03, 16'h0020);
        o = oe1_cyc;
        sclk_cycle(4'h0, din);
        qd = 4'h0;
        #(HALF);
        n_tests++; if (oe1_cyc !== o) begin n_fail++; $display("FAIL dummy_oe_early got %0d cycles expected 0", oe1_cyc - o); end
        sclk = 1'b1;
        #(HALF);
        n_tests++; if (oe1 !== 4'h0) begin n_fail++; $display("FAIL dummy_oe_last got %h expected 0", oe1); end
        sclk = 1'b0;
        sclk_cycle(4'h0, hi);
        sclk_cycle(4'h0, lo);
        n_tests++; if (hi !== 4'h5) begin n_fail++; $display("FAIL dummy_nibble_hi got %h expected 5", hi); end
        n_tests++; if (lo !== 4'hA) begin n_fail++; $display("FAIL dummy_nibble_lo got %h expected a", lo); end
        rx = {hi, lo};
        e = exp_q.pop_front();
        n_tests++; if (rx !== e) begin n_fail++; $display("FAIL dummy_byte got %h expected %h", rx, e); end
        end_xfer();
        n_tests++; if (oe1_cyc === o) begin n_fail++; $display("FAIL dummy_oe_data got 0 cycles expected nonzero"); end
        n_tests++; if (bc1 !== 16'd1) begin n_fail++; $display("FAIL dummy_byte_count got %0d expected 1", bc1); end
        n_tests++; if (done1_cnt - d !== 1) begin n_fail++; $display("FAIL dummy_done got %0d expected 1", done1_cnt - d); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx, e, g;
        int d, o;
        sel = 0; lanes = 2;
        e = ref0[8'h10];
        begin_xfer(8'h03, 16'h0010);
        xfer_byte(8'h00, rx);
        n_tests++; if (rx !== e) begin n_fail++; $display("FAIL midrst_first got %h expected %h", rx, e); end
        #(HALF / 2);
        n_tests++; if (oe0 !== 2'b11) begin n_fail++; $display("FAIL midrst_oe_before got %b expected 11", oe0); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (oe0 !== 2'b00) begin n_fail++; $display("FAIL midrst_oe got %b expected 00", oe0); end
        n_tests++; if (bc0 !== 16'd0) begin n_fail++; $display("FAIL midrst_byte_count got %0d expected 0", bc0); end
        n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %b expected 0", err0); end
        rst = 1'b1;
        d = done0_cnt; o = oe0_cyc;
        xfer_byte(8'h02, rx);
        xfer_byte(8'h00, rx);
        xfer_byte(8'h10, rx);
        xfer_byte(8'hEE, rx);
        end_xfer();
        n_tests++; if (oe0_cyc !== o) begin n_fail++; $display("FAIL midrst_ignore_oe got %0d cycles expected 0", oe0_cyc - o); end
        n_tests++; if (done0_cnt !== d) begin n_fail++; $display("FAIL midrst_ignore_done got %0d expected 0", done0_cnt - d); end
        n_tests++; if (bc0 !== 16'd0) begin n_fail++; $display("FAIL midrst_ignore_count got %0d expected 0", bc0); end
        do_read(16'h0010, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL midrst_ram got %h expected %h", g, e); end
        end
    endtask

    initial begin
        rst = 1'b0; ss0 = 1'b1; ss1 = 1'b1; sclk = 1'b0; qd = 4'h0;
        sel = 0; lanes = 2;
        repeat (4) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        test_write_read();
        test_wrap();
        test_partial_byte();
        test_reject();
        test_dummy_quad();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/qspi_memory_slave.md
Name: qspi_memory_slave

Overview:
Parametrised successor to the dual-lane SPI memory slave: a 1/2/4-lane SPI target backed by an internal byte RAM. It runs in the fast system clock domain and oversamples the external SS and SCLK pins. The chip top connects it to SB_IO tristate pads through per-lane read, write and output-enable vectors. Adds over the previous generation: configurable lane count, depth and address width, read dummy cycles, address wrap, command rejection and a transfer-status output.

Parameters:
LANES, 2, data lanes per SCLK edge; legal values 1, 2 or 4.
DEPTH, 256, RAM size in bytes; power of two, 16 to 4096.
ADDR_BYTES, 2, number of address bytes sent after the command; 1 to 3.
DUMMY_CYCLES, 0, SCLK cycles between the address and read data; 0 to 15.

Ports:
CLK  in  1  system clock, at least 8x the SCLK frequency.
RST  in  1  reset; synchronous, active-low.
SS  in  1  chip select from pad, active-low, asynchronous to CLK.
SCLK  in  1  SPI clock from pad (mode 0), asynchronous to CLK.
QD_READ  in  LANES  pad input values.
QD_WRITE  out  LANES  pad output values.
QD_WRITE_ENABLE  out  LANES  pad output enables, all bits equal.
XFER_DONE  out  1  one-CLK pulse when SS rises after a valid transaction.
BYTE_COUNT  out  16  data bytes moved in the last transaction; saturates at 0xFFFF.
CMD_ERR  out  1  sticky flag set by an unknown command; cleared by reset.

Behaviour:
- Reset (RST=0 at a CLK edge): QD_WRITE=0, QD_WRITE_ENABLE=0, XFER_DONE=0, BYTE_COUNT=0, CMD_ERR=0, FSM goes to IDLE. RAM contents are not cleared.
- Reset mid-transaction: outputs return to their reset values on the next CLK edge. The slave ignores the bus until SS goes high and then low again.
- Synchronisation:
  - SS and SCLK each pass through 2-FF synchronisers, then edge detection.
  - Rise and fall events occur 3 CLK after the pin edge.
  - QD_READ is sampled from a 2-FF delayed copy aligned to the SCLK rise event.
- Bit order: MSB first. Each SCLK rise shifts in LANES bits; lane LANES-1 carries the most significant bit. One byte takes 8/LANES SCLK cycles.
- FSM states: IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, REJECT.
  - IDLE -> CMD on SS fall.
  - CMD: on byte complete, 0x02 -> ADDR (write), 0x03 -> ADDR (read). Any other value -> REJECT and set CMD_ERR.
  - ADDR: collect ADDR_BYTES bytes, big-endian. Only the low log2(DEPTH) bits are used; higher bits are ignored. Then:
    - write -> WR_DATA;
    - read with DUMMY_CYCLES>0 -> DUMMY;
    - read with DUMMY_CYCLES=0 -> RD_DATA.
  - DUMMY: count DUMMY_CYCLES SCLK rises with outputs disabled, then go to RD_DATA.
  - WR_DATA: each completed byte is written to RAM[addr] on the CLK after its final rise event. Then addr = (addr+1) mod DEPTH and BYTE_COUNT increments.
  - RD_DATA:
    - The byte at addr is prefetched when the state is entered.
    - QD_WRITE_ENABLE goes high and the first lane group is driven on the SCLK fall event that ends the last address or dummy cycle.
    - Each later lane group updates on each SCLK fall event.
    - At a byte boundary the next prefetched byte is loaded and addr wraps mod DEPTH.
    - BYTE_COUNT increments per completed byte.
  - REJECT: ignore the bus; outputs stay disabled.
  - Any state -> IDLE on SS rise.
    - Outputs are disabled on that CLK.
    - A partial byte is discarded and never written.
    - XFER_DONE pulses only if the transaction reached RD_DATA or WR_DATA.
    - BYTE_COUNT holds until the next SS fall, then clears to 0.
- Simultaneous SS rise and SCLK edge in the same CLK: SS rise wins and the SCLK edge is ignored.
- QD_WRITE_ENABLE is never high outside RD_DATA.

Test Plan:
- LANES=2, ADDR_BYTES=2: write cmd 0x02, addr 0x0010, data A1 B2 C3 D4, then read cmd 0x03, addr 0x0010 -> MISO returns A1 B2 C3 D4; BYTE_COUNT=4 after each; XFER_DONE pulses twice.
- DEPTH=256: write 3 bytes at 0x00FE -> RAM[0xFE], RAM[0xFF] and RAM[0x00] are written; read from 0x01FF returns RAM[0xFF] then RAM[0x00] (high address bits ignored).
- SS raised after 2 SCLK of the 2nd data byte (LANES=2) -> only the first byte is written; BYTE_COUNT=1; OE stays low.
- Command 0x9F -> CMD_ERR=1; OE is 0 for the whole transaction; no XFER_DONE; RAM unchanged; a following valid read still works.
- LANES=4, DUMMY_CYCLES=2: read 0x0020 holding 0x5A -> OE low through both dummy cycles; data phase drives nibbles 5 then A.
- RST=0 during RD_DATA -> OE=0 and BYTE_COUNT=0 on the next CLK; the bus is ignored until a new SS fall.
